// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module  : mc_ctrl_pkg
// Brief   : State, opcode, funct and control-select encodings for the
//           multi-cycle controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;

    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;

    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_AND  = 3'b010;
    localparam logic [2:0] c_ALU_OR   = 3'b011;
    localparam logic [2:0] c_ALU_SLT  = 3'b100;

    localparam logic [1:0] c_PC_SEQ    = 2'b00;
    localparam logic [1:0] c_PC_BRANCH = 2'b01;
    localparam logic [1:0] c_PC_JUMP   = 2'b10;

    localparam logic [1:0] c_RD_RT    = 2'b00;
    localparam logic [1:0] c_RD_RD    = 2'b01;
    localparam logic [1:0] c_RD_RA    = 2'b10;

    localparam logic [1:0] c_DB_ALU   = 2'b00;
    localparam logic [1:0] c_DB_MEM   = 2'b01;
    localparam logic [1:0] c_DB_PC4   = 2'b10;

    typedef struct packed {
        logic rtype;
        logic addi;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic halt;
        logic nop;
    } instr_class_t;

    // Returns {valid, alu_op}; valid is low for funct codes we do not execute.
    function automatic logic [3:0] f_funct_decode(input logic [5:0] funct);
        logic [3:0] r;
        case (funct)
            c_FN_ADD: r = {1'b1, c_ALU_ADD};
            c_FN_SUB: r = {1'b1, c_ALU_SUB};
            c_FN_AND: r = {1'b1, c_ALU_AND};
            c_FN_OR:  r = {1'b1, c_ALU_OR};
            c_FN_SLT: r = {1'b1, c_ALU_SLT};
            default:  r = {1'b0, c_ALU_ADD};
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_control_fsm_if.sv
// ============================================================================
// Module  : mc_control_fsm_if
// Brief   : Instruction/status inputs and control outputs between the
//           controller (master) and the datapath (slave).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       PCWre;
    logic [1:0] PCSrc;
    logic       IRWre;
    logic       RegWre;
    logic [1:0] RegDst;
    logic       ALUSrcB;
    logic       ExtSel;
    logic [2:0] ALUOp;
    logic       mRD;
    logic       mWR;
    logic [1:0] DBDataSrc;
    logic [2:0] state;
    logic       halted;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output PCWre, PCSrc, IRWre, RegWre, RegDst, ALUSrcB, ExtSel,
               ALUOp, mRD, mWR, DBDataSrc, state, halted
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  PCWre, PCSrc, IRWre, RegWre, RegDst, ALUSrcB, ExtSel,
               ALUOp, mRD, mWR, DBDataSrc, state, halted
    );
endinterface

`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
// ============================================================================
// Module  : mc_ctrl_decode
// Brief   : Combinational opcode/funct decode into instruction class flags
//           and the EXE-cycle ALU operation.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
    input  wire logic [5:0] i_opcode,
    input  wire logic [5:0] i_funct,
    output instr_class_t    o_cls,
    output logic [2:0]      o_alu_op
);

    logic [3:0] w_fn;

    assign w_fn = f_funct_decode(i_funct);

    always_comb begin
        o_cls    = '0;
        o_alu_op = c_ALU_ADD;
        // The halt opcode wins even if it is configured onto a real opcode.
        if (i_opcode == HALT_OPCODE) begin
            o_cls.halt = 1'b1;
        end else begin
            case (i_opcode)
                c_OP_RTYPE: begin
                    if (w_fn[3]) begin
                        o_cls.rtype = 1'b1;
                        o_alu_op    = w_fn[2:0];
                    end else begin
                        o_cls.nop   = 1'b1;
                    end
                end
                c_OP_ADDI: o_cls.addi = 1'b1;
                c_OP_ORI: begin
                    o_cls.ori = 1'b1;
                    o_alu_op  = c_ALU_OR;
                end
                c_OP_LW:   o_cls.lw = 1'b1;
                c_OP_SW:   o_cls.sw = 1'b1;
                c_OP_BEQ: begin
                    o_cls.beq = 1'b1;
                    o_alu_op  = c_ALU_SUB;
                end
                c_OP_BNE: begin
                    o_cls.bne = 1'b1;
                    o_alu_op  = c_ALU_SUB;
                end
                c_OP_J:    o_cls.j   = 1'b1;
                c_OP_JAL:  o_cls.jal = 1'b1;
                default:   o_cls.nop = 1'b1;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
// Module  : mc_control_fsm
// Brief   : Multi-cycle MIPS-subset controller: IF/ID/EXE/MEM/WB/HALT state
//           register with control outputs decoded from state and inputs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
    input  wire logic        CLK,
    input  wire logic        RST,
    mc_control_fsm_if.master bus
);

    state_t       r_state;
    state_t       w_next;
    instr_class_t w_cls;
    logic [2:0]   w_dec_alu_op;

    logic         w_pcwre;
    logic [1:0]   w_pcsrc;
    logic         w_irwre;
    logic         w_regwre;
    logic [1:0]   w_regdst;
    logic         w_alusrcb;
    logic         w_extsel;
    logic [2:0]   w_aluop;
    logic         w_mrd;
    logic         w_mwr;
    logic [1:0]   w_dbsrc;
    logic         w_take;

    mc_ctrl_decode #(
        .HALT_OPCODE (HALT_OPCODE)
    ) u_decode (
        .i_opcode (bus.opcode),
        .i_funct  (bus.funct),
        .o_cls    (w_cls),
        .o_alu_op (w_dec_alu_op)
    );

    assign w_take = (w_cls.beq & bus.zero) | (w_cls.bne & ~bus.zero);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pcwre   = 1'b0;
        w_pcsrc   = c_PC_SEQ;
        w_irwre   = 1'b0;
        w_regwre  = 1'b0;
        w_regdst  = c_RD_RT;
        w_alusrcb = 1'b0;
        w_extsel  = 1'b0;
        w_aluop   = c_ALU_ADD;
        w_mrd     = 1'b0;
        w_mwr     = 1'b0;
        w_dbsrc   = c_DB_ALU;
        case (r_state)
            S_IF: begin
                w_irwre = 1'b1;
                w_next  = S_ID;
            end
            S_ID: begin
                if (w_cls.halt) begin
                    w_next = S_HALT;
                end else if (w_cls.j) begin
                    w_pcwre = 1'b1;
                    w_pcsrc = c_PC_JUMP;
                    w_next  = S_IF;
                end else if (w_cls.jal) begin
                    w_pcwre  = 1'b1;
                    w_pcsrc  = c_PC_JUMP;
                    w_regwre = 1'b1;
                    w_regdst = c_RD_RA;
                    w_dbsrc  = c_DB_PC4;
                    w_next   = S_IF;
                end else if (w_cls.nop) begin
                    w_pcwre = 1'b1;
                    w_next  = S_IF;
                end else begin
                    w_next = S_EXE;
                end
            end
            S_EXE: begin
                if (w_cls.beq | w_cls.bne) begin
                    w_aluop = w_dec_alu_op;
                    w_pcwre = 1'b1;
                    w_pcsrc = w_take ? c_PC_BRANCH : c_PC_SEQ;
                    w_next  = S_IF;
                end else if (w_cls.lw | w_cls.sw) begin
                    w_aluop   = w_dec_alu_op;
                    w_alusrcb = 1'b1;
                    w_extsel  = 1'b1;
                    w_next    = S_MEM;
                end else if (w_cls.rtype | w_cls.addi | w_cls.ori) begin
                    w_aluop  = w_dec_alu_op;
                    w_extsel = w_cls.addi;
                    w_next   = S_WB;
                end else begin
                    w_next = S_IF;
                end
            end
            S_MEM: begin
                // Strobes stay up for the whole wait; PC advances only on completion.
                w_mrd = w_cls.lw;
                w_mwr = w_cls.sw;
                if (!(w_cls.lw | w_cls.sw)) begin
                    w_next = S_IF;
                end else if (bus.mem_ready) begin
                    if (w_cls.sw) begin
                        w_pcwre = 1'b1;
                        w_next  = S_IF;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                w_regwre = 1'b1;
                w_pcwre  = 1'b1;
                w_regdst = w_cls.rtype ? c_RD_RD : c_RD_RT;
                w_dbsrc  = w_cls.lw ? c_DB_MEM : c_DB_ALU;
                w_next   = S_IF;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IF;
            end
        endcase
    end

    // Reset kills every enable/strobe combinationally, not just at the next edge.
    assign bus.PCWre     = w_pcwre  & ~RST;
    assign bus.PCSrc     = RST ? c_PC_SEQ  : w_pcsrc;
    assign bus.IRWre     = w_irwre  & ~RST;
    assign bus.RegWre    = w_regwre & ~RST;
    assign bus.RegDst    = RST ? c_RD_RT   : w_regdst;
    assign bus.ALUSrcB   = w_alusrcb & ~RST;
    assign bus.ExtSel    = w_extsel  & ~RST;
    assign bus.ALUOp     = RST ? c_ALU_ADD : w_aluop;
    assign bus.mRD       = w_mrd & ~RST;
    assign bus.mWR       = w_mwr & ~RST;
    assign bus.DBDataSrc = RST ? c_DB_ALU  : w_dbsrc;
    assign bus.state     = r_state;
    assign bus.halted    = (r_state == S_HALT) & ~RST;

endmodule

`default_nettype wire
